spi_master_byte: RTL
====================

// Module: spi_master_byte
// PURPOSE
//   Byte-wide SPI master (mode 0, MSB first) inside Processor. Drives spi_clk/spi_mosi/spi_cs_n, samples spi_miso.
//   Processor core writes a byte and strobes start; block shifts 8 bits, returns received byte with a done pulse.
//   hold_cs keeps chip select asserted across multi-byte flash/peripheral transactions.
// PARAMETERS
//   DIV      4   CLK cycles per SCLK half-period; legal range >= 1 (SCLK = CLK/(2*DIV))
// PORTS
//   CLK        in   1  system clock, all logic on rising edge
//   reset      in   1  asynchronous, active-high reset
//   start      in   1  request transfer; accepted only when busy=0
//   tx_data    in   8  byte to send, captured on accepting edge
//   hold_cs    in   1  1 = keep spi_cs_n low after this byte
//   rx_data    out  8  byte received; updated with done, held until next done
//   busy       out  1  transfer in progress
//   done       out  1  one-cycle pulse, rx_data valid
//   spi_clk    out  1  SCLK, idles low
//   spi_mosi   out  1  serial data out
//   spi_miso   in   1  serial data in
//   spi_cs_n   out  1  chip select, active low
// BEHAVIOUR
//   Reset: asynchronous, active-high. Immediate and mid-transfer:
//     spi_cs_n=1, spi_clk=0, spi_mosi=0, busy=0, done=0, rx_data=8'h00, state=IDLE, counters=0.
//   States: IDLE -> SETUP -> SHIFT -> IDLE.
//   IDLE
//     start=1: tx_data into shift reg; next cycle spi_cs_n=0, busy=1, spi_mosi=tx_data[7].
//     Go to SETUP.
//   SETUP: DIV cycles CS-to-first-edge setup, spi_clk=0. Then SHIFT.
//   SHIFT: 16 half-periods of DIV cycles each. spi_clk toggles at end of each half-period.
//     Rising toggle: spi_miso sampled into shift reg LSB.
//     Falling toggle: shift left; spi_mosi = new MSB.
//     After 16th toggle (spi_clk back to 0):
//       done=1 for one cycle; rx_data = shift reg; busy=0; go to IDLE.
//   Latency: done asserted exactly 17*DIV+1 CLK cycles after the start-accepting edge (DIV=4 -> 69).
//   Exactly 8 rising SCLK edges per byte. spi_mosi stable for >= DIV cycles around each rising edge.
//   CS release
//     hold_cs sampled in done cycle.
//     hold_cs=0: spi_cs_n=1 in the done cycle.
//     hold_cs=1: spi_cs_n stays 0 in IDLE until a cycle with hold_cs=0 and no start; spi_cs_n=1 on the next edge.
//     A start while CS held reuses the low CS but still runs SETUP.
//   Boundaries
//     start while busy=1 (incl. SETUP/SHIFT): ignored, tx_data not captured.
//     start in the done cycle: ignored; earliest accept is the following cycle.
//     start and hold_cs=0 together in IDLE with CS held: start wins, CS stays low.
//     spi_mosi returns to 0 in IDLE after done.
//   Arithmetic
//     Half-period counter width $clog2(DIV+1), wraps to 0 on expiry.
//     Toggle counter 5 bits, 0..16.
// STRUCTURE
//   Shared package (processor_pkg)
//     SPI state encoding localparams: IDLE, SETUP, SHIFT.
//     SPI_BITS=8.
//   Sub-module: spi_clk_tick
//     DIV-cycle half-period counter with enable/clear.
//     Emits one-cycle tick used by the FSM for setup and SCLK toggles.
//   Remainder in one file: FSM, shift register, CS logic.
// TESTING
//   1. Assert reset with CLK stopped -> spi_cs_n=1, spi_clk=0, spi_mosi=0, busy=0, done=0, rx_data=00 immediately.
//   2. DIV=4, spi_miso looped to spi_mosi, start tx=A5, hold_cs=0:
//      -> 8 rising edges; done at cycle 69; rx_data=A5; spi_cs_n=1 in done cycle.
//   3. spi_miso=1, tx=3C:
//      -> mosi at rising edges 0,0,1,1,1,1,0,0; rx_data=FF; busy high from cycle 1 through cycle 68.
//   4. hold_cs=1, bytes 12 then 34 (second start one cycle after done):
//      -> spi_cs_n low continuously; start pulsed mid-SHIFT is ignored.
//      Then hold_cs=0 -> spi_cs_n=1 next edge.
//   5. reset asserted after 3rd rising SCLK edge:
//      -> outputs at reset values same cycle; no done pulse.
//      After release, new transfer tx=C3 completes with rx_data correct.
//   6. DIV=1 build, loopback tx=81 -> done at cycle 18, rx_data=81.

Source files
------------

// File: rtl/processor_pkg.sv
// processor_pkg: shared SPI master state encoding and byte width
package processor_pkg;
    localparam int SPI_BITS = 8;
    typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, SHIFT = 2'd2} spi_state_t;
endpackage

// File: rtl/spi_clk_tick.sv
// spi_clk_tick: DIV-cycle half-period counter emitting a one-cycle tick on expiry
module spi_clk_tick #(
    parameter int DIV = 4
) (
    input  logic CLK,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int W = $clog2(DIV + 1);
    logic [W-1:0] cnt;
    assign tick = en && cnt == W'(DIV - 1);
    always_ff @(posedge CLK or posedge reset)
        if (reset) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/spi_master_byte.sv
// spi_master_byte: mode-0 MSB-first byte SPI master with optional held chip select
module spi_master_byte
    import processor_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic                start,
    input  logic [SPI_BITS-1:0] tx_data,
    input  logic                hold_cs,
    output logic [SPI_BITS-1:0] rx_data,
    output logic                busy,
    output logic                done,
    output logic                spi_clk,
    output logic                spi_mosi,
    input  logic                spi_miso,
    output logic                spi_cs_n
);
    spi_state_t          state;
    logic [SPI_BITS-1:0] sr;
    logic [4:0]          tcnt;
    logic                miso_q;
    logic                tick;
    logic                last;
    assign last = state == SHIFT && tcnt == 5'd16;
    spi_clk_tick #(.DIV(DIV)) u_tick (
        .CLK  (CLK),
        .reset(reset),
        .en   (state != IDLE && !last),
        .clr  (state == IDLE),
        .tick (tick)
    );
    // miso is held in miso_q on the rising toggle and shifted in on the falling one,
    // so the outgoing LSB is never overwritten before it is sent
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            sr       <= '0;
            tcnt     <= '0;
            miso_q   <= 1'b0;
            rx_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            spi_clk  <= 1'b0;
            spi_mosi <= 1'b0;
            spi_cs_n <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE:
                    if (start && !done) begin
                        sr       <= tx_data;
                        spi_mosi <= tx_data[SPI_BITS-1];
                        spi_cs_n <= 1'b0;
                        busy     <= 1'b1;
                        tcnt     <= '0;
                        state    <= SETUP;
                    end else if (!hold_cs && !start) spi_cs_n <= 1'b1;
                SETUP: if (tick) state <= SHIFT;
                SHIFT:
                    if (last) begin
                        done     <= 1'b1;
                        rx_data  <= sr;
                        busy     <= 1'b0;
                        spi_mosi <= 1'b0;
                        spi_cs_n <= !hold_cs;
                        state    <= IDLE;
                    end else if (tick) begin
                        spi_clk <= !spi_clk;
                        tcnt    <= tcnt + 5'd1;
                        if (!spi_clk) miso_q <= spi_miso;
                        else begin
                            sr       <= {sr[SPI_BITS-2:0], miso_q};
                            spi_mosi <= sr[SPI_BITS-2];
                        end
                    end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
